// File: rtl/mac_psum_accumulator.sv
// Partial-sum accumulator: sums ACC_LEN signed products into one result on a valid/ready output.
// Define MAC_PSUM_ACC_SAT_EN to saturate the result to OUT_WIDTH instead of wrapping.
module mac_psum_accumulator #(
   parameter int PSUM_WIDTH = 20,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 16,
   parameter int ACC_LEN    = 64
) (
   input  logic                  s_clk,
   input  logic                  s_rst,
   input  logic [PSUM_WIDTH-1:0] psum_in,
   input  logic                  psum_vld,
   input  logic                  flush,
   output logic [OUT_WIDTH-1:0]  acc_out,
   output logic                  acc_vld,
   input  logic                  acc_rdy,
   output logic [15:0]           grp_cnt,
   output logic                  ovf_err
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_ACC  = 1'b1;

   localparam logic [15:0] LEN = 16'(ACC_LEN);

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic [0:0]                   state;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [ACC_WIDTH-1:0]  psum_ext;
   logic signed [ACC_WIDTH-1:0]  sum_next;
   logic [15:0]                  cnt_next;
   logic                         complete;
   logic [OUT_WIDTH-1:0]         result;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      psum_ext = ACC_WIDTH'($signed(psum_in));
      sum_next = acc;
      cnt_next = grp_cnt;
      if (psum_vld) begin
         if (state == S_IDLE) begin
            sum_next = psum_ext;
            cnt_next = 16'd1;
         end else begin
            sum_next = acc + psum_ext;
            cnt_next = grp_cnt + 16'd1;
         end
      end
      // A flush only closes something if a group is open or opening this cycle.
      complete = (psum_vld && (cnt_next == LEN)) ||
                 (flush && ((state == S_ACC) || psum_vld));
   end

   always_comb begin
`ifdef MAC_PSUM_ACC_SAT_EN
      if (sum_next > SAT_MAX)
         result = SAT_MAX[OUT_WIDTH-1:0];
      else if (sum_next < SAT_MIN)
         result = SAT_MIN[OUT_WIDTH-1:0];
      else
         result = sum_next[OUT_WIDTH-1:0];
`else
      result = sum_next[OUT_WIDTH-1:0];
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         state   <= S_IDLE;
         acc     <= '0;
         grp_cnt <= '0;
      end else if (complete) begin
         state   <= S_IDLE;
         acc     <= '0;
         grp_cnt <= '0;
      end else begin
         acc     <= sum_next;
         grp_cnt <= cnt_next;
         if (psum_vld)
            state <= S_ACC;
      end
   end

   // A completion is dropped only when the held result is still waiting on acc_rdy.
   always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) begin
         acc_out <= '0;
         acc_vld <= 1'b0;
         ovf_err <= 1'b0;
      end else if (complete) begin
         if (!acc_vld || acc_rdy) begin
            acc_out <= result;
            acc_vld <= 1'b1;
         end else begin
            ovf_err <= 1'b1;
         end
      end else if (acc_vld && acc_rdy) begin
         acc_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mac_psum_accumulator.sv
// Self-checking bench for mac_psum_accumulator (ACC_LEN=4): directed plan plus random traffic
// against a group-list reference model.
module tb_mac_psum_accumulator;

   localparam int PW = 20;
   localparam int OW = 16;
   localparam int AL = 4;

   logic          s_clk = 1'b0;
   logic          s_rst;
   logic [PW-1:0] psum_in;
   logic          psum_vld;
   logic          flush;
   logic [OW-1:0] acc_out;
   logic          acc_vld;
   logic          acc_rdy;
   logic [15:0]   grp_cnt;
   logic          ovf_err;

   int checks = 0;
   int errors = 0;

   // Reference model: the products of the open group, plus the expected output register.
   int          grp_q[$];
   bit          m_vld;
   bit          m_ovf;
   logic [15:0] m_out;

   mac_psum_accumulator #(
      .PSUM_WIDTH(PW), .ACC_WIDTH(32), .OUT_WIDTH(OW), .ACC_LEN(AL)
   ) dut (
      .s_clk(s_clk), .s_rst(s_rst), .psum_in(psum_in), .psum_vld(psum_vld),
      .flush(flush), .acc_out(acc_out), .acc_vld(acc_vld), .acc_rdy(acc_rdy),
      .grp_cnt(grp_cnt), .ovf_err(ovf_err)
   );

   always #5 s_clk = ~s_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] convert(input longint s);
      logic signed [31:0] t;
      t = s[31:0];
`ifdef MAC_PSUM_ACC_SAT_EN
      if (t > 32767) return 16'h7fff;
      if (t < -32768) return 16'h8000;
`endif
      return t[15:0];
   endfunction

   task automatic model_reset();
      grp_q.delete();
      m_vld = 1'b0;
      m_ovf = 1'b0;
      m_out = '0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".vld"}, 32'(acc_vld), 32'(m_vld));
      check({tag, ".out"}, 32'(acc_out), 32'(m_out));
      check({tag, ".cnt"}, 32'(grp_cnt), 32'(grp_q.size()));
      check({tag, ".ovf"}, 32'(ovf_err), 32'(m_ovf));
   endtask

   // Apply one cycle of inputs, advance the model, then compare just after the edge.
   task automatic step(input string tag, input bit v, input int p, input bit f, input bit r);
      bit     accept;
      bit     done;
      longint s;
      psum_vld = v;
      psum_in  = p[PW-1:0];
      flush    = f;
      acc_rdy  = r;
      accept = m_vld && r;
      if (v) grp_q.push_back(p);
      done = (v && grp_q.size() == AL) || (f && grp_q.size() > 0);
      if (done) begin
         s = 0;
         foreach (grp_q[i]) s += grp_q[i];
         grp_q.delete();
         if (!m_vld || r) begin
            m_out = convert(s);
            m_vld = 1'b1;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (accept) begin
         m_vld = 1'b0;
      end
      @(posedge s_clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      int vals[4];
      s_rst    = 1'b1;
      psum_in  = '0;
      psum_vld = 1'b0;
      flush    = 1'b0;
      acc_rdy  = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(posedge s_clk);
      @(negedge s_clk);
      s_rst = 1'b0;

      // Basic group: 3 -5 7 10 -> 15, valid for one cycle.
      vals = '{3, -5, 7, 10};
      foreach (vals[i]) step("basic", 1'b1, vals[i], 1'b0, 1'b1);
      check("basic.sum", 32'(acc_out), 32'd15);
      step("basic.drop", 1'b0, 0, 1'b0, 1'b1);

      // Back-to-back groups of +1 then +2.
      for (int i = 0; i < 8; i++) step("b2b", 1'b1, (i < 4) ? 1 : 2, 1'b0, 1'b1);
      check("b2b.sum", 32'(acc_out), 32'd8);
      step("b2b.idle", 1'b0, 0, 1'b0, 1'b1);

      // Flush with a same-cycle product, then a flush in idle.
      step("flush", 1'b1, 100, 1'b0, 1'b1);
      step("flush", 1'b1, 200, 1'b0, 1'b1);
      step("flush.vld", 1'b1, -50, 1'b1, 1'b1);
      check("flush.sum", 32'(acc_out), 32'd250);
      step("flush.idle", 1'b0, 0, 1'b1, 1'b1);
      step("flush.idle2", 1'b0, 0, 1'b1, 1'b1);

      // Backpressure: 15 is held, 40 is dropped.
      vals = '{1, 2, 3, 9};
      foreach (vals[i]) step("bp.g1", 1'b1, vals[i], 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step("bp.g2", 1'b1, 10, 1'b0, 1'b0);
      check("bp.hold", 32'(acc_out), 32'd15);
      check("bp.ovf", 32'(ovf_err), 32'd1);
      step("bp.accept", 1'b0, 0, 1'b0, 1'b1);

      // Width conversion at both extremes.
      for (int i = 0; i < 4; i++) step("wid.pos", 1'b1, 20000, 1'b0, 1'b1);
`ifdef MAC_PSUM_ACC_SAT_EN
      check("wid.pos.sum", 32'(acc_out), 32'h7fff);
`else
      check("wid.pos.sum", 32'(acc_out), 32'd14464);
`endif
      for (int i = 0; i < 4; i++) step("wid.neg", 1'b1, -20000, 1'b0, 1'b1);
`ifdef MAC_PSUM_ACC_SAT_EN
      check("wid.neg.sum", 32'(acc_out), 32'h8000);
`else
      check("wid.neg.sum", 32'(acc_out), 32'hc780);
`endif

      // Asynchronous reset between edges discards a partial group.
      step("rst.pre", 1'b1, 5, 1'b0, 1'b1);
      step("rst.pre", 1'b1, 6, 1'b0, 1'b1);
      #2;
      s_rst = 1'b1;
      #1;
      model_reset();
      check_all("rst.async");
      #1;
      s_rst = 1'b0;
      for (int i = 0; i < 4; i++) step("rst.post", 1'b1, 1, 1'b0, 1'b1);
      check("rst.sum", 32'(acc_out), 32'd4);

      // Random traffic with random flushes and backpressure.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] r;
         int          p;
         r = $urandom();
         p = int'({{12{r[19]}}, r[19:0]});
         step("rand", ($urandom_range(0, 3) != 0), p,
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_psum_accumulator.md
Name: mac_psum_accumulator

Overview:
- Downstream stage of the pipelined signed multiplier unit in the systolic datapath.
- Consumes the multiplier's product stream (`psum_in`/`psum_vld`) and sums ACC_LEN consecutive valid products into one dot-product result.
- Presents each result on a valid/ready output register toward the spiking/threshold stage.
- Also supports early flush of a partial group, and flags results lost to output backpressure.

Parameters:
- PSUM_WIDTH, 20: width of the signed product input; matches the multiplier result width.
- ACC_WIDTH, 32: internal signed accumulator width. Must be ≥ PSUM_WIDTH + clog2(ACC_LEN).
- OUT_WIDTH, 16: signed result width on `acc_out`.
- ACC_LEN, 64: products per group. Legal range 1..65535.

Ports:
- `s_clk`, input, 1: single clock, rising edge.
- `s_rst`, input, 1: asynchronous, active-high reset.
- `psum_in`, input, PSUM_WIDTH: signed product from the multiplier.
- `psum_vld`, input, 1: `psum_in` is valid this cycle. There is no backpressure upstream.
- `flush`, input, 1: close the current group early.
- `acc_out`, output, OUT_WIDTH: signed group result.
- `acc_vld`, output, 1: `acc_out` is valid.
- `acc_rdy`, input, 1: downstream accepts `acc_out` when `acc_vld` && `acc_rdy`.
- `grp_cnt`, output, 16: number of products accumulated in the current open group.
- `ovf_err`, output, 1: sticky flag. Set when a completed result is dropped.

Behaviour:
- Reset (async, `s_rst`=1): `acc_out`=0, `acc_vld`=0, `grp_cnt`=0, `ovf_err`=0, accumulator=0, state=S_IDLE. Reset mid-group discards the partial sum.
- States:
  - S_IDLE: `grp_cnt`=0.
  - S_ACC: group open, 1 ≤ `grp_cnt` < ACC_LEN.
- Input arithmetic: `psum_in` is sign-extended to ACC_WIDTH. Summation is two's complement and wraps at ACC_WIDTH.
- `psum_vld`=1 in S_IDLE:
  - Accumulator is loaded with `psum_in` (not added to a stale value).
  - `grp_cnt`=1, state → S_ACC.
  - If ACC_LEN=1, the group completes immediately; see "Group completion".
- `psum_vld`=1 in S_ACC: accumulator += `psum_in`, `grp_cnt`++.
- Group completion, on any of:
  - the ACC_LEN-th valid product, or
  - `flush`=1 while a group is open, or
  - `flush`=1 together with `psum_vld`.
- Completion action:
  - The final sum (including any same-cycle product) goes to the output register.
  - Accumulator=0, `grp_cnt`=0, state → S_IDLE.
  - Latency: `acc_vld` rises on the clock edge after the cycle carrying the last product, i.e. 1 cycle.
- Flush in S_IDLE with `psum_vld`=0: ignored; no output produced.
- Flush with `psum_vld`=1 in S_IDLE: emits a 1-element result (`psum_in`).
- Output register handshake:
  - `acc_vld` holds, and `acc_out` stays stable, until `acc_vld` && `acc_rdy`. `acc_vld` then clears the next edge, unless a new completion occurs in the same cycle.
  - Completion in the same cycle as acceptance: new result loads and `acc_vld` stays 1 (back-to-back, no bubble).
  - Completion while `acc_vld`=1 and `acc_rdy`=0: the new result is dropped, the old result is kept, and `ovf_err` is set.
  - `ovf_err` clears only on reset.
- Accumulation never stalls; inputs keep being accepted every cycle regardless of output state.
- Output width conversion: see Optional Feature.

Optional Feature:
- Macro: `MAC_PSUM_ACC_SAT_EN`.
- Defined: the completed ACC_WIDTH sum is clamped to the signed OUT_WIDTH range [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1] before loading `acc_out`.
- Undefined: `acc_out` takes the low OUT_WIDTH bits of the sum (two's-complement wrap).

Test Plan (ACC_LEN=4, OUT_WIDTH=16 unless noted):
1. Basic group: `psum_vld` on 4 consecutive cycles with 3, −5, 7, 10, `acc_rdy`=1 → `acc_out`=15 and `acc_vld`=1 for exactly one cycle, one edge after the 4th input; `grp_cnt` sequence 1, 2, 3, 0.
2. Back-to-back groups: 8 consecutive products, all +1 then all +2, `acc_rdy`=1 → results 4 then 8 on consecutive groups with no lost result; `ovf_err`=0.
3. Flush: inputs 100, 200, then `flush` asserted with `psum_vld`=1 and `psum_in`=−50 → `acc_out`=250, `grp_cnt`=0. Flush alone in S_IDLE → no `acc_vld`.
4. Backpressure: `acc_rdy`=0, two full groups summing to 15 and 40 → `acc_out` holds 15 and `ovf_err`=1. Then `acc_rdy`=1 → 15 accepted, `acc_vld` drops.
5. Width handling: inputs 20000 ×4 → 32767 with `MAC_PSUM_ACC_SAT_EN` defined; 14464 without. Inputs −20000 ×4 → −32768 with the macro defined.
6. Async reset: assert `s_rst` after 2 inputs, between clock edges → all outputs 0 immediately. After release, inputs 1, 1, 1, 1 → `acc_out`=4 (no residue from before reset).
